// File: rtl/scan_demux_pkg.sv
// Shared types and sizes for the four-channel scan demultiplexer.
// Slot and settle-counter widths match a 4:1 external mux.
package scan_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/scan_demux_settle_timer.sv
// Settle-window counter: cleared by load, advanced by inc, flags when it reaches term.
// The flag is combinational from the count so the FSM sees it in the same cycle.
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == term);

endmodule

// File: rtl/four_one_scan_demux.sv
// Scans an external 4:1 mux through slots 0..3, samples its output after a settle
// window, and publishes each complete four-channel frame atomically on y.
module four_one_scan_demux
    import scan_demux_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] y,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    always_comb begin
        assert (SETTLE_CYCLES >= 1 && SETTLE_CYCLES <= 15)
            else $error("SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
    end

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-2:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   y_q, y_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                tmr_load, tmr_inc, tmr_tc;

    settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .inc   (tmr_inc),
        .term  (TERM),
        .tc    (tmr_tc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_inc      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (en) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                    shadow_d = '0;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // The last slot completes even if en has just fallen.
                if (sel_q == LAST) begin
                    y_d          = {din, shadow_q};
                    frame_done_d = 1'b1;
                    sel_d        = '0;
                    tmr_load     = 1'b1;
                    state_d      = en ? ST_SETTLE : ST_IDLE;
                end else if (!en) begin
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                    shadow_d = '0;
                    tmr_load = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_CH - 1; k++) begin
                        if (sel_q == SEL_W'(k)) shadow_d[k] = din;
                    end
                    sel_d    = sel_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sel_d    = '0;
                tmr_load = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge values computed above.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            // NOTE: shadow is three flops rather than a RAM, so it is cleared with the rest of the state.
            shadow_q     <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign y          = y_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_four_one_scan_demux.sv
// Bench for four_one_scan_demux: instance a uses SETTLE_CYCLES=2, instance b uses 1.
// Each mux model is direct or delayed two cycles; published frames are scoreboarded.
module tb_four_one_scan_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic       din_a, din_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] y_a, y_b;
    logic       fd_a, fd_b, busy_a, busy_b;

    logic [3:0] mux_in = 4'b0000;   // {D, C, B, A}
    logic       delay_mode = 1'b0;
    logic [1:0] hist_a1 = '0, hist_a2 = '0, hist_b1 = '0, hist_b2 = '0;

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist_a1 <= sel_a;
        hist_a2 <= hist_a1;
        hist_b1 <= sel_b;
        hist_b2 <= hist_b1;
    end

    assign din_a = delay_mode ? mux_in[hist_a2] : mux_in[sel_a];
    assign din_b = delay_mode ? mux_in[hist_b2] : mux_in[sel_b];

    four_one_scan_demux #(.SETTLE_CYCLES(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_a),
        .din        (din_a),
        .sel        (sel_a),
        .y          (y_a),
        .frame_done (fd_a),
        .busy       (busy_a)
    );

    four_one_scan_demux #(.SETTLE_CYCLES(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_b),
        .din        (din_b),
        .sel        (sel_b),
        .y          (y_b),
        .frame_done (fd_b),
        .busy       (busy_b)
    );

    // Scoreboard: every frame_done pops one expected frame.
    always @(negedge clk) begin
        if (fd_a) begin
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL sb_a_unexpected: frame_done with y=%b, no frame expected", y_a);
            end else begin
                logic [3:0] e;
                e = exp_a.pop_front();
                if (y_a !== e) begin
                    n_err++;
                    $display("FAIL sb_a_y: got %b expected %b", y_a, e);
                end
            end
        end
        if (fd_b) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL sb_b_unexpected: frame_done with y=%b, no frame expected", y_b);
            end else begin
                logic [3:0] e;
                e = exp_b.pop_front();
                if (y_b !== e) begin
                    n_err++;
                    $display("FAIL sb_b_y: got %b expected %b", y_b, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_en(input bit which, input logic v);
        if (which) en_b = v;
        else       en_a = v;
    endtask

    function automatic logic [1:0] get_sel(input bit which);
        return which ? sel_b : sel_a;
    endfunction

    function automatic logic get_fd(input bit which);
        return which ? fd_b : fd_a;
    endfunction

    function automatic logic get_busy(input bit which);
        return which ? busy_b : busy_a;
    endfunction

    // One frame from IDLE with en dropped in the final CAPTURE cycle.
    task automatic run_frame(input bit which, input int sc, input logic [3:0] exp_y,
                             input string tag);
        int flen;
        flen = 4 * (sc + 1);
        if (which) exp_b.push_back(exp_y);
        else       exp_a.push_back(exp_y);
        set_en(which, 1'b1);
        for (int c = 1; c <= flen; c++) begin
            step();
            n_cmp++;
            if (get_sel(which) !== 2'((c - 1) / (sc + 1))) begin
                n_err++;
                $display("FAIL %s_sel_c%0d: got %0d expected %0d", tag, c, get_sel(which),
                         (c - 1) / (sc + 1));
            end
            n_cmp++;
            if (get_busy(which) !== 1'b1 || get_fd(which) !== 1'b0) begin
                n_err++;
                $display("FAIL %s_busy_fd_c%0d: got busy=%b fd=%b expected busy=1 fd=0",
                         tag, c, get_busy(which), get_fd(which));
            end
            if (c == flen) set_en(which, 1'b0);
        end
        step();
        n_cmp++;
        if (get_fd(which) !== 1'b1 || get_busy(which) !== 1'b0 || get_sel(which) !== 2'd0) begin
            n_err++;
            $display("FAIL %s_publish: got fd=%b busy=%b sel=%0d expected fd=1 busy=0 sel=0",
                     tag, get_fd(which), get_busy(which), get_sel(which));
        end
        step();
        n_cmp++;
        if (get_fd(which) !== 1'b0 || get_busy(which) !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: got fd=%b busy=%b expected fd=0 busy=0",
                     tag, get_fd(which), get_busy(which));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({sel_a, y_a, fd_a, busy_a} !== 8'h00 || {sel_b, y_b, fd_b, busy_b} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got a=%b b=%b expected all zero",
                     {sel_a, y_a, fd_a, busy_a}, {sel_b, y_b, fd_b, busy_b});
        end
        rst_n = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy_a=%b busy_b=%b expected 0", busy_a, busy_b);
        end
    endtask

    task automatic test_single_frame();
        delay_mode = 1'b0;
        mux_in = 4'b1001;   // A=1 B=0 C=0 D=1
        run_frame(1'b0, 2, 4'b1001, "single");
        step();
    endtask

    task automatic test_settle();
        delay_mode = 1'b1;
        mux_in = 4'b0110;   // A=0 B=1 C=1 D=0
        repeat (3) step();
        run_frame(1'b0, 2, 4'b0110, "settle2");
        repeat (3) step();
        // One settle cycle samples the channel selected two cycles earlier: A, A, B, C.
        run_frame(1'b1, 1, 4'b1100, "settle1");
        n_cmp++;
        if (y_b === 4'b0110) begin
            n_err++;
            $display("FAIL settle1_differs: got %b expected anything but 0110", y_b);
        end
        delay_mode = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        exp_a.push_back(4'b0101);
        exp_a.push_back(4'b0101);
        mux_in = 4'b1010;
        en_a = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 2) mux_in = 4'b0101;
            n_cmp++;
            if (fd_a !== (c == 13) || busy_a !== 1'b1 || sel_a !== 2'(((c - 1) % 12) / 3)) begin
                n_err++;
                $display("FAIL b2b_c%0d: got fd=%b busy=%b sel=%0d expected fd=%b busy=1 sel=%0d",
                         c, fd_a, busy_a, sel_a, c == 13, ((c - 1) % 12) / 3);
            end
            if (c == 24) en_a = 1'b0;
        end
        step();
        n_cmp++;
        if (fd_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got fd=%b busy=%b expected fd=1 busy=0", fd_a, busy_a);
        end
        step();
    endtask

    task automatic test_abort();
        exp_a.push_back(4'b1001);
        mux_in = 4'b1001;
        en_a = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c == 19) en_a = 1'b0;
        end
        step();
        n_cmp++;
        if (busy_a !== 1'b0 || sel_a !== 2'd0 || fd_a !== 1'b0 || y_a !== 4'b1001) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%b sel=%0d fd=%b y=%b expected 0 0 0 1001",
                     busy_a, sel_a, fd_a, y_a);
        end
        mux_in = 4'b0110;
        repeat (10) begin
            step();
            n_cmp++;
            if (fd_a !== 1'b0 || busy_a !== 1'b0 || y_a !== 4'b1001) begin
                n_err++;
                $display("FAIL abort_hold: got fd=%b busy=%b y=%b expected 0 0 1001",
                         fd_a, busy_a, y_a);
            end
        end
        run_frame(1'b0, 2, 4'b0110, "restart");
    endtask

    task automatic test_late_drop();
        mux_in = 4'b0011;
        run_frame(1'b0, 2, 4'b0011, "late");
    endtask

    task automatic test_reset_mid_frame();
        en_a = 1'b1;
        for (int c = 1; c <= 7; c++) step();
        n_cmp++;
        if (sel_a !== 2'd2 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got sel=%0d busy=%b expected sel=2 busy=1", sel_a, busy_a);
        end
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (sel_a !== 2'd0 || y_a !== 4'b0000 || busy_a !== 1'b0 || fd_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got sel=%0d y=%b busy=%b fd=%b expected 0 0000 0 0",
                     sel_a, y_a, busy_a, fd_a);
        end
        rst_n = 1'b1;
        en_a = 1'b0;
        step();
        n_cmp++;
        if (busy_a !== 1'b0 || y_a !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset: got busy=%b y=%b expected 0 0000", busy_a, y_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_settle();
        test_back_to_back();
        test_abort();
        test_late_drop();
        test_reset_mid_frame();
        n_cmp++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d/%0d frames outstanding expected 0/0",
                     exp_a.size(), exp_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
